// File: rtl/elevator_call_reg.sv
// Elevator call register: synchronizes raw hall/cabin buttons, latches new presses,
// clears calls served at an open-door floor, and reports call position summaries.
module elevator_call_reg #(
    parameter int NFLOOR = 8,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NFLOOR-1:1] btup,
    input  logic [NFLOOR:2]   btdn,
    input  logic [NFLOOR:1]   in_bt_floor,
    input  logic [NFLOOR:1]   floor,
    input  logic              door_open,
    input  logic              dir_up,
    input  logic              dir_dn,
    output logic [NFLOOR-1:1] req_up,
    output logic [NFLOOR:2]   req_dn,
    output logic [NFLOOR:1]   req_cab,
    output logic              call_above,
    output logic              call_below,
    output logic              call_here,
    output logic [CNT_W-1:0]  pending_cnt
);

    // All button bits share one flat vector: cabin in the low slice, then down, then up.
    localparam int TOT = 3 * NFLOOR - 2;

    logic [TOT-1:0]    raw;
    logic [TOT-1:0]    sync_p0;
    logic [TOT-1:0]    sync_p1;
    logic [TOT-1:0]    sync_p2;
    logic [TOT-1:0]    rise;
    logic [TOT-1:0]    clr;
    logic [TOT-1:0]    req_q;
    logic [NFLOOR:1]   any_call;
    logic              floor_oh;
    logic              idle;
    logic              clr_en;

    assign raw = {btup, btdn, in_bt_floor};

    // Stage p0/p1: metastability filter; p2: previous synchronized level for edge detect
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
            req_q   <= '0;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            req_q   <= (req_q | rise) & ~clr;
        end
    end

    assign rise = sync_p1 & ~sync_p2;

    assign floor_oh = (floor != '0) && ((floor & (floor - 1'b1)) == '0);
    assign idle     = (dir_up == dir_dn);
    assign clr_en   = door_open & floor_oh;

    // Clear is applied after the set, so a coincident set/clear leaves the bit served.
    assign clr = {floor[NFLOOR-1:1] & {(NFLOOR-1){clr_en & (dir_up | idle)}},
                  floor[NFLOOR:2]   & {(NFLOOR-1){clr_en & (dir_dn | idle)}},
                  floor             & {NFLOOR{clr_en}}};

    assign req_cab = req_q[NFLOOR-1:0];
    assign req_dn  = req_q[2*NFLOOR-2:NFLOOR];
    assign req_up  = req_q[TOT-1:2*NFLOOR-1];

    assign any_call = req_cab | {1'b0, req_up} | {req_dn, 1'b0};

    always_comb begin
        call_above = 1'b0;
        call_below = 1'b0;
        call_here  = 1'b0;
        if (floor_oh) begin
            for (int f = 1; f <= NFLOOR; f++) begin
                if (floor[f]) begin
                    for (int i = 1; i <= NFLOOR; i++) begin
                        if (i > f)
                            call_above = call_above | any_call[i];
                        else if (i < f)
                            call_below = call_below | any_call[i];
                        else
                            call_here = call_here | any_call[i];
                    end
                end
            end
        end
    end

    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < TOT; i++)
            pending_cnt = pending_cnt + CNT_W'(req_q[i]);
    end

endmodule

// File: doc/elevator_call_reg.md
ELEVATOR_CALL_REG -- requirements
Module: elevator_call_reg

Interface
REQ-001 Parameter: NFLOOR, 8, number of floors, numbered 1..NFLOOR; all floor vectors are indexed [NFLOOR:1] unless stated.
REQ-002 Parameter: CNT_W, 5, width of pending_cnt; must satisfy 2^CNT_W > 3*NFLOOR-2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 btup  input  [NFLOOR-1:1]  raw hall-up buttons, asynchronous, level.
REQ-006 btdn  input  [NFLOOR:2]  raw hall-down buttons, asynchronous, level.
REQ-007 in_bt_floor  input  [NFLOOR:1]  raw cabin floor buttons, asynchronous, level.
REQ-008 floor  input  [NFLOOR:1]  current car position, one-hot, synchronous to clk.
REQ-009 door_open  input  1  car door open at the current floor, synchronous.
REQ-010 dir_up / dir_dn  input  1 each  committed travel direction; both 0 means idle.
REQ-011 req_up  output  [NFLOOR-1:1]  latched hall-up calls.
REQ-012 req_dn  output  [NFLOOR:2]  latched hall-down calls.
REQ-013 req_cab  output  [NFLOOR:1]  latched cabin calls.
REQ-014 call_above / call_below / call_here  output  1 each  any latched call strictly above / strictly below / at the current floor.
REQ-015 pending_cnt  output  [CNT_W-1:0]  total number of latched call bits.

Function
REQ-016 Each raw button bit passes through a 2-flop synchronizer, then a rising-edge detector (third flop holds the previous synchronized value).
REQ-017 A detected rising edge sets the matching request bit; a set takes effect on the 3rd rising clk edge after the raw input is first sampled high.
REQ-018 A button held high sets its bit only once; a further set requires release for at least one synchronized cycle, followed by a new press.
REQ-019 Pressing a button whose bit is already set has no effect.
REQ-020 Clear condition: door_open=1 and floor one-hot with bit f set.
REQ-021 Under the clear condition, req_cab[f] is cleared on the next edge.
REQ-022 Under the clear condition, req_up[f] is cleared on the next edge if dir_up=1 or the car is idle.
REQ-023 Under the clear condition, req_dn[f] is cleared on the next edge if dir_dn=1 or the car is idle.
REQ-024 If dir_up=1 and dir_dn=1 together, the car is treated as idle (both hall bits at f are cleared).
REQ-025 If floor is not one-hot (zero or multiple bits set), no bit is cleared and call_above, call_below and call_here are 0.
REQ-026 If a set and a clear of the same bit occur on the same edge, the clear wins (the call counts as served).
REQ-027 Sets and clears on different bits in the same cycle both take effect.
REQ-028 call_above, call_below, call_here and pending_cnt are combinational from the request registers and floor, with zero latency; pending_cnt is the popcount of req_up, req_dn and req_cab.
REQ-029 Bits outside the legal ranges (up at NFLOOR, down at 1) do not exist and are never reported.

Reset
REQ-030 While rst=0, all synchronizer, edge and request flops are 0 asynchronously; all outputs read 0.
REQ-031 After release, a button held through reset is detected as a rising edge and latched once.
REQ-032 Reset asserted mid-operation discards all pending calls immediately, without waiting for a clock edge.

Verification
REQ-033 Press in_bt_floor[5] with floor=8'b0000_0001 and idle -> req_cab[5]=1 at edge 3; call_above=1, call_below=0, pending_cnt=1.
REQ-034 Hold btup[3] for 20 cycles; floor=3, door_open=1, dir_up=1 from cycle 10 -> req_up[3] sets once, then clears and stays 0 while the button is still held.
REQ-035 Latch btup[4] and btdn[4]; floor=4, door_open=1, dir_dn=1 -> req_dn[4] clears, req_up[4] stays 1, call_here=1, pending_cnt=1.
REQ-036 Press in_bt_floor[2] on the same cycle its synchronized edge coincides with floor=2, door_open=1 -> req_cab[2] remains 0.
REQ-037 Latch all 22 calls, then drive floor=8'b0000_0110 with door_open=1 -> nothing clears, pending_cnt=22, and call_above, call_below and call_here are all 0.
REQ-038 Assert rst=0 between clock edges with calls pending -> all outputs 0 before the next edge.
